// File: rtl/miriscv_instr_prefetch_buffer.sv
// Instruction prefetch buffer between the fetch unit and the instruction bus.
// Streams sequential words into a small FIFO ahead of the fetch unit; a fetch
// whose address matches the FIFO head is served on the next cycle, any other
// fetch address flushes the FIFO and restarts the stream there.
module miriscv_instr_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            instr_req_i,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic            instr_rvalid_o,
    output logic [XLEN-1:0] instr_rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    typedef enum logic {IDLE, RUN} state_e;
    state_e state_q, state_d;

    logic [XLEN-1:0] fifo_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, inflight_q, inflight_d, discard_q;
    logic [XLEN-1:0] head_addr_q, pf_addr_q;

    logic hit, stall, flush, gnt_fire, issue, push, pop;

    // State register
    always_ff @(posedge clk_i) begin
        if (!arstn_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: leave IDLE on the first fetch, never return
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && instr_req_i) state_d = RUN;
    end

    // Request classification, credit check and FIFO handshakes
    always_comb begin
        hit      = instr_req_i && (count_q != '0) && (instr_addr_i == head_addr_q);
        stall    = instr_req_i && (count_q == '0) && (instr_addr_i == head_addr_q)
                   && (state_q == RUN);
        flush    = instr_req_i && !hit && !stall;
        gnt_fire = mem_req_o && mem_gnt_i;
        // inflight already covers the pending request, so the sum is the
        // number of FIFO slots spoken for; it never grows in a cycle without issue
        issue    = (state_q == RUN) && !flush && (!mem_req_o || gnt_fire)
                   && (({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
        // responses arriving with a flush belong to the old stream
        push     = mem_rvalid_i && (discard_q == '0) && !flush;
        pop      = hit;
        inflight_d = inflight_q + CW'(issue) - CW'(mem_rvalid_i);
    end

    // Bus request, prefetch address and credit/discard accounting
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            pf_addr_q  <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            if (issue) begin
                mem_req_o  <= 1'b1;
                mem_addr_o <= pf_addr_q;
            end else if (gnt_fire) begin
                mem_req_o  <= 1'b0;
            end
            if (flush)      pf_addr_q <= instr_addr_i;
            else if (issue) pf_addr_q <= pf_addr_q + XLEN'(4);
            inflight_q <= inflight_d;
            // a flush turns everything still outstanding into stale traffic
            if (flush)                                discard_q <= inflight_d;
            else if (mem_rvalid_i && discard_q != '0) discard_q <= discard_q - CW'(1);
        end
    end

    // FIFO pointers, occupancy and head address
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_addr_q <= '0;
        end else if (flush) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_addr_q <= instr_addr_i;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                head_addr_q <= head_addr_q + XLEN'(4);
            end
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // FIFO storage; contents are meaningless while count is zero
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= mem_rdata_i;
    end

    // Fetch response: valid one cycle after a hit, data held otherwise
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= NOP;
        end else begin
            instr_rvalid_o <= hit;
            if (hit) instr_rdata_o <= fifo_q[rd_ptr_q];
        end
    end

`ifndef SYNTHESIS
    // Credits must keep the FIFO from ever overflowing
    assert property (@(posedge clk_i) disable iff (!arstn_i)
                     !(push && !pop && count_q == DEPTH_C));
`endif

endmodule

// File: tb/tb_miriscv_instr_prefetch_buffer.sv
// Bench for the prefetch buffer: a bus model (grant/response queue) and a
// fetch-side scoreboard that checks every delivered word against its address.
module tb_miriscv_instr_prefetch_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A   = 32'h8000_0000;
    localparam logic [31:0] B   = 32'h8000_0100;
    localparam logic [31:0] C   = 32'h8000_0200;

    logic        clk = 1'b0;
    logic        arstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    typedef struct { logic req; logic [31:0] addr; } sb_t;
    sb_t         sb[$];
    logic [31:0] bq[$];
    logic [31:0] issued[$];
    logic        gnt_en, rv_en;
    logic [31:0] last_data;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    miriscv_instr_prefetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i          (clk),
        .arstn_i        (arstn_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Bus: grant per gnt_en, one response per cycle per rv_en, one cycle after grant
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk); #1;
            if (!arstn_i) begin
                bq.delete();
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            end else begin
                mem_rvalid_i = 1'b0;
                if (rv_en && bq.size() > 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = word(bq.pop_front());
                end
                mem_gnt_i = gnt_en;
                if (mem_req_o && gnt_en) begin
                    bq.push_back(mem_addr_o);
                    issued.push_back(mem_addr_o);
                end
            end
        end
    end

    // One fetch-side cycle: drive, record expectation, compare the response
    task automatic step(input logic req, input logic [31:0] a, output logic got);
        sb_t e;
        instr_req_i = req; instr_addr_i = a;
        sb.push_back('{req, a});
        @(negedge clk);
        e   = sb.pop_front();
        got = instr_rvalid_o;
        if (!e.req) begin
            chk("rvalid_idle", 32'(instr_rvalid_o), 32'd0);
            chk("rdata_hold", instr_rdata_o, last_data);
        end else if (instr_rvalid_o) begin
            chk("rdata", instr_rdata_o, word(e.addr));
            last_data = word(e.addr);
        end
    endtask

    // Re-present an address until it is delivered; cyc = cycles taken
    task automatic fetch(input logic [31:0] a, output int cyc);
        logic got;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 40) begin
            step(1'b1, a, got);
            cyc++;
        end
        chk("fetch_done", 32'(got), 32'd1);
    endtask

    task automatic idle(input int n);
        logic got;
        repeat (n) step(1'b0, 32'h0, got);
    endtask

    task automatic do_reset();
        arstn_i = 1'b0; instr_req_i = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_rvalid", 32'(instr_rvalid_o), 32'd0);
        chk("rst_rdata", instr_rdata_o, NOP);
        @(negedge clk);
        sb.delete(); issued.delete();
        last_data = NOP;
        arstn_i = 1'b1;
    endtask

    initial begin
        int          cyc, n0, n1;
        logic        got;
        logic [31:0] pend;
        arstn_i = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0;
        gnt_en = 1'b1; rv_en = 1'b1; last_data = NOP;
        @(negedge clk);
        do_reset();

        // Boot fetch, then sequential stream hitting every cycle
        fetch(A, cyc);
        chk("boot_issue0", issued[0], A);
        chk("boot_issue1", issued[1], A + 32'd4);
        for (int k = 1; k < 8; k++) begin
            fetch(A + 32'(4 * k), cyc);
            chk("seq_lat", 32'(cyc), 32'd1);
        end

        // Let the FIFO fill: no requests while full, one pop frees one issue
        idle(8);
        chk("full_noreq", 32'(mem_req_o), 32'd0);
        n0 = issued.size();
        idle(3);
        chk("full_noissue", 32'(issued.size()), 32'(n0));
        fetch(A + 32'd32, cyc);
        chk("full_hit_lat", 32'(cyc), 32'd1);
        idle(4);
        chk("one_issue", 32'(issued.size()), 32'(n0 + 1));
        for (int i = 0; i < issued.size(); i++)
            chk("issue_seq", issued[i], A + 32'(4 * i));

        // Branch with 3 transactions outstanding: stale responses dropped
        rv_en = 1'b0;
        n0 = issued.size();
        step(1'b1, 32'h8000_0040, got);
        idle(3);
        rv_en = 1'b1;
        fetch(B, cyc);
        chk("br_stale0", issued[n0],     32'h8000_0040);
        chk("br_stale2", issued[n0 + 2], 32'h8000_0048);
        chk("br_target", issued[n0 + 3], B);
        fetch(B + 32'd4, cyc);
        chk("br_seq_lat", 32'(cyc), 32'd1);
        fetch(B + 32'd8, cyc);

        // Pending request held without grant, across a flush, then discarded
        idle(8);
        gnt_en = 1'b0;
        fetch(B + 32'd12, cyc);
        idle(1);
        pend = issued[$] + 32'd4;
        chk("pend_req", 32'(mem_req_o), 32'd1);
        chk("pend_addr", mem_addr_o, pend);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("pend_hold_req", 32'(mem_req_o), 32'd1);
            chk("pend_hold_addr", mem_addr_o, pend);
        end
        n1 = issued.size();
        step(1'b1, C, got);
        chk("flush_hold_req", 32'(mem_req_o), 32'd1);
        chk("flush_hold_addr", mem_addr_o, pend);
        gnt_en = 1'b1;
        fetch(C, cyc);
        chk("pend_granted", issued[n1], pend);
        chk("pend_next", issued[n1 + 1], C);

        // Address wrap at the top of the address space
        idle(8);
        n1 = issued.size();
        fetch(32'hFFFF_FFF8, cyc);
        fetch(32'hFFFF_FFFC, cyc);
        chk("wrap_lat1", 32'(cyc), 32'd1);
        fetch(32'h0000_0000, cyc);
        chk("wrap_lat2", 32'(cyc), 32'd1);
        chk("wrap_issue0", issued[n1],     32'hFFFF_FFF8);
        chk("wrap_issue1", issued[n1 + 1], 32'hFFFF_FFFC);
        chk("wrap_issue2", issued[n1 + 2], 32'h0000_0000);

        // Reset with two transactions in flight, then a clean restart
        idle(8);
        rv_en = 1'b0;
        step(1'b1, 32'h8000_0080, got);
        idle(2);
        do_reset();
        rv_en = 1'b1;
        fetch(32'h8000_0300, cyc);
        chk("rst_restart", issued[0], 32'h8000_0300);
        fetch(32'h8000_0304, cyc);
        chk("rst_seq_lat", 32'(cyc), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
